pipe_fetch: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register of the 5-stage RV32I core. It owns the PC and issues one outstanding request at a time to instruction memory, which has variable response latency. It honours execute-stage redirects and hazard-unit stall/flush, and drives the decode stage with `instr_D`, `PC_D`, `PC4_D` and `valid_D`.

---
 rtl/riscv_pkg.sv | 28 ++
 rtl/fetch_ifid_reg.sv | 68 ++++++
 rtl/pipe_fetch.sv | 135 +++++++++++++
 tb/tb_pipe_fetch.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types for the RV32I fetch stage: FSM states, the IF/ID payload and the NOP bubble.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    HOLD
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
  } ifid_t;

  function automatic ifid_t ifid_bubble();
    ifid_t b;
    b.instr = NOP_INSTR;
    b.pc    = 32'h0;
    b.pc4   = 32'h0;
    b.valid = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/fetch_ifid_reg.sv
// IF/ID pipeline register: stall holds, flush or no new instruction loads a NOP bubble.
// FETCH_PERF_EN adds a wrapping counter of bubble loads.
module fetch_ifid_reg
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        load_valid,
  input  ifid_t       load_data,
  output ifid_t       ifid
`ifdef FETCH_PERF_EN
  ,output logic [31:0] perf_bubble_cnt
`endif
);

  ifid_t ifid_q, ifid_d;
  logic  bubble_load;

  always_comb begin
    ifid_d      = ifid_q;
    bubble_load = 1'b0;
    if (stall) begin
      ifid_d = ifid_q;
    end else if (flush || !load_valid) begin
      ifid_d      = ifid_bubble();
      bubble_load = 1'b1;
    end else begin
      ifid_d = load_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifid_q <= ifid_bubble();
    end else begin
      ifid_q <= ifid_d;
    end
  end

  assign ifid = ifid_q;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (bubble_load) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_q <= 32'h0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_bubble_cnt = perf_q;
`else
  logic unused_bubble;
  assign unused_bubble = bubble_load;
`endif

endmodule

// File: rtl/pipe_fetch.sv
// Instruction fetch stage: PC, one-outstanding-request IMEM FSM and the IF/ID register.
// Optional bubble counter port enabled by FETCH_PERF_EN.
module pipe_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_E,
  input  logic [31:0] redirect_pc_E,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_D,
  output logic [31:0] PC_D,
  output logic [31:0] PC4_D,
  output logic        valid_D
`ifdef FETCH_PERF_EN
  ,output logic [31:0] perf_bubble_cnt
`endif
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         kill_q, kill_d;
  logic [31:0]  buf_instr_q, buf_instr_d;

  logic [31:0]  pc_plus4;
  logic [31:0]  redirect_target;
  logic         new_valid;
  logic [31:0]  new_instr;
  ifid_t        load_data;
  ifid_t        ifid;

  assign pc_plus4        = pc_q + 32'd4;
  assign redirect_target = redirect_pc_E & 32'hFFFF_FFFC;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    kill_d      = kill_q;
    buf_instr_d = buf_instr_q;
    new_valid   = 1'b0;
    new_instr   = imem_rdata;
    case (state_q)
      REQ: begin
        if (redirect_E) begin
          pc_d = redirect_target;
        end else begin
          state_d = WAIT;
          kill_d  = 1'b0;
        end
      end
      WAIT: begin
        if (redirect_E) begin
          pc_d   = redirect_target;
          kill_d = 1'b1;
        end
        if (imem_rvalid) begin
          // A response is stale if a redirect arrived earlier or in this very cycle
          if (kill_q || redirect_E) begin
            state_d = REQ;
          end else if (!stall) begin
            new_valid = 1'b1;
            new_instr = imem_rdata;
            pc_d      = pc_plus4;
            state_d   = REQ;
          end else begin
            buf_instr_d = imem_rdata;
            state_d     = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect_E) begin
          pc_d    = redirect_target;
          state_d = REQ;
        end else if (!stall) begin
          new_valid = 1'b1;
          new_instr = buf_instr_q;
          pc_d      = pc_plus4;
          state_d   = REQ;
        end
      end
      default: state_d = REQ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= REQ;
      pc_q        <= RESET_PC;
      kill_q      <= 1'b0;
      buf_instr_q <= NOP_INSTR;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_q      <= kill_d;
      buf_instr_q <= buf_instr_d;
    end
  end

  assign imem_req  = (state_q == REQ) && !redirect_E && !reset;
  assign imem_addr = pc_q;

  always_comb begin
    load_data.instr = new_instr;
    load_data.pc    = pc_q;
    load_data.pc4   = pc_plus4;
    load_data.valid = 1'b1;
  end

  fetch_ifid_reg u_ifid (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .flush           (flush),
    .load_valid      (new_valid),
    .load_data       (load_data),
    .ifid            (ifid)
`ifdef FETCH_PERF_EN
    ,.perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  assign instr_D = ifid.instr;
  assign PC_D    = ifid.pc;
  assign PC4_D   = ifid.pc4;
  assign valid_D = ifid.valid;

endmodule

// File: tb/tb_pipe_fetch.sv
// Self-checking bench for pipe_fetch: variable-latency IMEM model plus a scoreboard of IF/ID loads.
module tb_pipe_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect_E = 1'b0;
  logic [31:0] redirect_pc_E = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr_D, PC_D, PC4_D;
  logic        valid_D;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_bubble_cnt;
`endif

  int checks = 0;
  int errors = 0;

  pipe_fetch #(.RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .redirect_E    (redirect_E),
    .redirect_pc_E (redirect_pc_E),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .instr_D       (instr_D),
    .PC_D          (PC_D),
    .PC4_D         (PC4_D),
    .valid_D       (valid_D)
`ifdef FETCH_PERF_EN
    ,.perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0050_0093;
    return ((a << 5) | 32'h13) ^ 32'h0AB0_0000;
  endfunction

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } exp_t;

  exp_t        exp_q[$];
  int          mem_lat = 1;
  int          drop_cnt = 0;
  int          cyc = 0;
  int          due_cyc = 0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;

  // Memory: capture requests on the rising edge, answer on a later falling edge
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pend <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (imem_req) begin
        pend      <= 1'b1;
        due_cyc   <= cyc + mem_lat;
        pend_addr <= imem_addr;
      end
    end
  end

  always @(negedge clk) begin
    imem_rvalid = 1'b0;
    if (!reset && pend && cyc == due_cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend_addr);
      if (drop_cnt > 0) drop_cnt = drop_cnt - 1;
      else exp_q.push_back({mem_word(pend_addr), pend_addr, pend_addr + 32'd4});
    end
  end

  logic mon_stall;
  exp_t mon_e;
  always @(posedge clk) begin
    mon_stall = stall;
    #1;
    if (!reset && !mon_stall && valid_D) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_load: got instr=%h pc=%h, no load expected", instr_D, PC_D);
      end else begin
        mon_e = exp_q.pop_front();
        if ({instr_D, PC_D, PC4_D} !== {mon_e.instr, mon_e.pc, mon_e.pc4}) begin
          errors++;
          $display("FAIL sb_load: got %h/%h/%h expected %h/%h/%h",
                   instr_D, PC_D, PC4_D, mon_e.instr, mon_e.pc, mon_e.pc4);
        end
      end
    end
  end

  task automatic wait_req(output logic ok, output logic [31:0] a);
    ok = 1'b0;
    a  = 32'h0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (imem_req) begin
        ok = 1'b1;
        a  = imem_addr;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL reset_req: got %b expected 0", imem_req);
    end
    checks++;
    if ({instr_D, PC_D, PC4_D, valid_D} !== {32'h13, 32'h0, 32'h0, 1'b0}) begin
      errors++; $display("FAIL reset_ifid: got %h/%h/%h/%b expected 13/0/0/0", instr_D, PC_D, PC4_D, valid_D);
    end
`ifdef FETCH_PERF_EN
    checks++;
    if (perf_bubble_cnt !== 32'h0) begin
      errors++; $display("FAIL reset_perf: got %0d expected 0", perf_bubble_cnt);
    end
`endif
    $display("test_reset done");
  endtask

  task automatic test_first_fetch();
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
      errors++; $display("FAIL first_req: got req=%b addr=%h expected 1/%h", imem_req, imem_addr, RST_PC);
    end
    @(negedge clk); #1;
    checks++;
    if (valid_D !== 1'b0) begin
      errors++; $display("FAIL first_early: got valid=%b expected 0", valid_D);
    end
    @(negedge clk); #1;
    checks++;
    if ({instr_D, PC_D, PC4_D, valid_D} !== {32'h0050_0093, 32'h100, 32'h104, 1'b1}) begin
      errors++; $display("FAIL first_ifid: got %h/%h/%h/%b expected 00500093/100/104/1", instr_D, PC_D, PC4_D, valid_D);
    end
    $display("test_first_fetch done");
  endtask

  task automatic test_back_to_back();
    logic        ok;
    logic [31:0] a0, a1;
    int          loads;
`ifdef FETCH_PERF_EN
    logic [31:0] p0;
`endif
    wait_req(ok, a0);
    wait_req(ok, a1);
    checks++;
    if (!ok || a1 !== a0 + 32'd4) begin
      errors++; $display("FAIL b2b_addr: got %h expected %h", a1, a0 + 32'd4);
    end
    loads = 0;
`ifdef FETCH_PERF_EN
    p0 = perf_bubble_cnt;
`endif
    repeat (10) begin
      @(negedge clk); #1;
      if (valid_D) loads++;
    end
    checks++;
    if (loads != 5) begin
      errors++; $display("FAIL b2b_rate: got %0d valid cycles expected 5", loads);
    end
`ifdef FETCH_PERF_EN
    checks++;
    if (perf_bubble_cnt - p0 !== 32'd5) begin
      errors++; $display("FAIL perf_delta: got %0d expected 5", perf_bubble_cnt - p0);
    end
`endif
    $display("test_back_to_back done");
  endtask

  task automatic test_stall_wait();
    logic        ok;
    logic [31:0] a;
    logic [96:0] snap;
    wait_req(ok, a);
    @(negedge clk);
    stall = 1'b1;
    #1;
    snap = {instr_D, PC_D, PC4_D, valid_D};
    repeat (2) begin
      @(negedge clk); #1;
      checks++;
      if (imem_req !== 1'b0 || {instr_D, PC_D, PC4_D, valid_D} !== snap) begin
        errors++; $display("FAIL stall_hold: got req=%b pc_d=%h expected req=0 pc_d=%h", imem_req, PC_D, snap[64:33]);
      end
    end
    @(negedge clk);
    stall = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL stall_release_req: got %b expected 0", imem_req);
    end
    @(negedge clk); #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== a + 32'd4 || valid_D !== 1'b1 || PC_D !== a) begin
      errors++; $display("FAIL stall_resume: got req=%b addr=%h pc_d=%h expected 1/%h/%h", imem_req, imem_addr, PC_D, a + 32'd4, a);
    end
    $display("test_stall_wait done");
  endtask

  task automatic test_redirect_wait();
    logic        ok;
    logic [31:0] a;
    wait_req(ok, a);
    mem_lat  = 3;
    drop_cnt = 1;
    @(negedge clk);
    redirect_E    = 1'b1;
    redirect_pc_E = 32'h200;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL redir_wait_req: got %b expected 0", imem_req);
    end
    @(negedge clk);
    redirect_E = 1'b0;
    mem_lat    = 1;
    #1;
    @(negedge clk); #1;
    checks++;
    if (imem_req !== 1'b0 || valid_D !== 1'b0) begin
      errors++; $display("FAIL redir_wait_resp: got req=%b valid=%b expected 0/0", imem_req, valid_D);
    end
    @(negedge clk); #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200 || valid_D !== 1'b0) begin
      errors++; $display("FAIL redir_wait_next: got req=%b addr=%h valid=%b expected 1/200/0", imem_req, imem_addr, valid_D);
    end
    $display("test_redirect_wait done");
  endtask

  task automatic test_redirect_rvalid();
    logic        ok;
    logic [31:0] a;
    wait_req(ok, a);
    drop_cnt = 1;
    @(negedge clk);
    redirect_E    = 1'b1;
    redirect_pc_E = 32'h203;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL redir_rv_req: got %b expected 0", imem_req);
    end
    @(negedge clk);
    redirect_E = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200 || valid_D !== 1'b0) begin
      errors++; $display("FAIL redir_rv_next: got req=%b addr=%h valid=%b expected 1/200/0", imem_req, imem_addr, valid_D);
    end
    $display("test_redirect_rvalid done");
  endtask

  task automatic test_flush();
    logic        ok;
    logic [31:0] a;
    logic [96:0] snap;
    wait_req(ok, a);
    drop_cnt = 1;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++;
    if ({instr_D, PC_D, PC4_D, valid_D} !== {32'h13, 32'h0, 32'h0, 1'b0}) begin
      errors++; $display("FAIL flush_bubble: got %h/%h/%h/%b expected 13/0/0/0", instr_D, PC_D, PC4_D, valid_D);
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== a + 32'd4) begin
      errors++; $display("FAIL flush_next: got req=%b addr=%h expected 1/%h", imem_req, imem_addr, a + 32'd4);
    end
    @(negedge clk);
    @(negedge clk); #1;
    snap = {instr_D, PC_D, PC4_D, valid_D};
    checks++;
    if (valid_D !== 1'b1 || PC_D !== a + 32'd4) begin
      errors++; $display("FAIL flush_refill: got valid=%b pc_d=%h expected 1/%h", valid_D, PC_D, a + 32'd4);
    end
    stall = 1'b1;
    flush = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({instr_D, PC_D, PC4_D, valid_D} !== snap) begin
      errors++; $display("FAIL stall_flush_hold: got pc_d=%h valid=%b expected %h/%b", PC_D, valid_D, snap[64:33], snap[0]);
    end
    stall = 1'b0;
    flush = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (valid_D !== 1'b1 || PC_D !== a + 32'd8) begin
      errors++; $display("FAIL stall_flush_after: got valid=%b pc_d=%h expected 1/%h", valid_D, PC_D, a + 32'd8);
    end
    $display("test_flush done");
  endtask

  task automatic test_wrap();
    logic        ok;
    logic [31:0] a;
    wait_req(ok, a);
    drop_cnt = 1;
    @(negedge clk);
    redirect_E    = 1'b1;
    redirect_pc_E = 32'hFFFF_FFFF;
    @(negedge clk);
    redirect_E = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_req: got req=%b addr=%h expected 1/fffffffc", imem_req, imem_addr);
    end
    @(negedge clk);
    @(negedge clk); #1;
    checks++;
    if (PC_D !== 32'hFFFF_FFFC || PC4_D !== 32'h0 || valid_D !== 1'b1) begin
      errors++; $display("FAIL wrap_ifid: got pc=%h pc4=%h valid=%b expected fffffffc/0/1", PC_D, PC4_D, valid_D);
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL wrap_next: got req=%b addr=%h expected 1/0", imem_req, imem_addr);
    end
    $display("test_wrap done");
  endtask

  task automatic test_drain();
    @(negedge clk);
    @(posedge clk); #2;
    checks++;
    if (exp_q.size() != 0 || drop_cnt != 0) begin
      errors++; $display("FAIL sb_drain: got %0d pending, %0d drops expected 0/0", exp_q.size(), drop_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_back_to_back();
    test_stall_wait();
    test_redirect_wait();
    test_redirect_rvalid();
    test_flush();
    test_wrap();
    test_back_to_back();
    test_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
